// File: rtl/uart_pkg.sv
// Shared UART constants and TX state encoding.
// Used by the memory-dump transmitter and the serial loader.
package uart_pkg;

    localparam int BAUD_CNT_W    = 13;
    localparam int DATA_BITS     = 8;
    localparam int LDR_NUM_BYTES = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } tx_state_e;

    function automatic logic even_parity(
        input logic [DATA_BITS-1:0] b
    );
        return ^b;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..Baudrate, pulses o_tick on the terminal count.
// i_clear holds it at zero so a frame always starts with a full-length bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned Baudrate = 2603
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [BAUD_CNT_W-1:0] TERM = BAUD_CNT_W'(Baudrate);

    logic [BAUD_CNT_W-1:0] r_cnt;

    assign o_tick = (r_cnt == TERM);

    // Free-running count with wrap on terminal value and synchronous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_mem_tx.sv
// UART transmitter that dumps a NUM_BYTES memory image, byte 0 first, LSB first.
// Define UART_TX_PARITY_EN for 8E1 frames (even parity bit before stop).
module uart_mem_tx
    import uart_pkg::*;
#(
    parameter int unsigned Baudrate  = 2603,
    parameter int unsigned NUM_BYTES = 32
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic [NUM_BYTES*8-1:0] memory_data,
    output logic                   TX,
    output logic                   Busy,
    output logic                   Done,
    output logic [4:0]             byte_index
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_BYTES - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e r_state;
    tx_state_e w_state_nxt;

    logic [NUM_BYTES*8-1:0] r_shadow;
    logic [4:0]             r_byte_idx;
    logic [4:0]             w_idx_nxt;
    logic [2:0]             r_bit_cnt;
    logic [2:0]             w_bit_nxt;
    logic                   w_load;
    logic                   w_tick;
    logic                   w_baud_clr;
    logic                   w_tx;
    logic [DATA_BITS-1:0]   w_cur_byte;
    logic                   w_data_bit;

    assign w_baud_clr = (r_state == S_IDLE);
    assign w_cur_byte = r_shadow[r_byte_idx*DATA_BITS +: DATA_BITS];
    assign w_data_bit = w_cur_byte[r_bit_cnt];

`ifdef UART_TX_PARITY_EN
    logic w_parity;
    assign w_parity = even_parity(w_cur_byte);
`endif

    uart_baud_tick #(
        .Baudrate (Baudrate)
    ) u_baud (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_clear (w_baud_clr),
        .o_tick  (w_tick)
    );

    // Next-state, byte/bit sequencing and TX line selection.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_byte_idx;
        w_bit_nxt   = r_bit_cnt;
        w_load      = 1'b0;
        w_tx        = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx = 1'b0;
                if (w_tick) begin
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_tx = w_data_bit;
                if (w_tick) begin
                    if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_tx = w_parity;
                if (w_tick) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (r_byte_idx == LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = r_byte_idx + 1'b1;
                        w_state_nxt = S_START;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and shadow image; reset aborts any frame in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_byte_idx <= '0;
            r_bit_cnt  <= '0;
            r_shadow   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_idx <= w_idx_nxt;
            r_bit_cnt  <= w_bit_nxt;
            if (w_load) begin
                r_shadow <= memory_data;
            end
        end
    end

    assign TX         = w_tx;
    assign Busy       = (r_state != S_IDLE);
    assign Done       = (r_state == S_DONE);
    assign byte_index = r_byte_idx;

endmodule

// File: tb/tb_uart_mem_tx.sv
// Scoreboard bench for uart_mem_tx (Baudrate=3, 4 cycles per bit).
// A serial receiver decodes TX and checks bytes against queued expectations.
module tb_uart_mem_tx;

    localparam int BIT_CYC = 4;
    localparam int NB      = 32;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int DUMP_CYC = NB * FRAME * BIT_CYC;

    typedef struct {
        logic [4:0] idx;
        logic [7:0] data;
    } sb_t;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           Start;
    logic [NB*8-1:0] memory_data;
    logic           TX;
    logic           Busy;
    logic           Done;
    logic [4:0]     byte_index;

    sb_t sb[$];
    int  n_vec  = 0;
    int  n_miss = 0;

    uart_mem_tx #(
        .Baudrate  (3),
        .NUM_BYTES (NB)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .memory_data (memory_data),
        .TX          (TX),
        .Busy        (Busy),
        .Done        (Done),
        .byte_index  (byte_index)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Serial receiver: samples mid-bit on the falling clock edge.
    int         rx_cnt = 0;
    bit         rx_on  = 0;
    logic [7:0] rx_data;
    sb_t        cur;
    always @(negedge Clk) begin
        if (Reset) begin
            rx_on = 0;
        end else if (!rx_on) begin
            if (TX === 1'b0) begin
                rx_on  = 1;
                rx_cnt = 0;
                if (sb.size() == 0) begin
                    chk("rx_unexpected", 1, 0);
                    cur.idx  = 'x;
                    cur.data = 'x;
                end else begin
                    cur = sb.pop_front();
                end
                chk("byte_index", byte_index, cur.idx);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % BIT_CYC == 2) begin
                int slot;
                slot = rx_cnt / BIT_CYC;
                if (slot == 0) begin
                    chk("start_bit", TX, 0);
                end else if (slot <= 8) begin
                    rx_data[slot-1] = TX;
                end else if (slot == FRAME - 1) begin
                    chk("stop_bit", TX, 1);
                    chk("rx_byte", rx_data, cur.data);
                    rx_on = 0;
                end else begin
                    chk("parity_bit", TX, ^cur.data);
                end
            end
        end
    end

    task automatic push_image(input logic [NB*8-1:0] img);
        sb_t e;
        for (int k = 0; k < NB; k++) begin
            e.idx  = 5'(k);
            e.data = img[k*8 +: 8];
            sb.push_back(e);
        end
    endtask

    // Full dump; optionally poke Start/memory_data mid-dump and Start on Done.
    task automatic dump(input logic [NB*8-1:0] img, input bit poke,
                        input bit start_on_done);
        int cyc;
        memory_data = img;
        Start = 1'b1;
        push_image(img);
        tick();
        Start = 1'b0;
        chk("busy_latency", Busy, 1);
        chk("tx_latency", TX, 0);
        cyc = 1;
        while (!Done && cyc < DUMP_CYC + 200) begin
            if (poke && cyc == 100) begin
                Start = 1'b1;
                memory_data = ~img;
            end
            if (poke && cyc == 104) Start = 1'b0;
            tick();
            if (!Done) cyc++;
        end
        chk("done_cycle", cyc, DUMP_CYC);
        chk("sb_empty", sb.size(), 0);
        if (start_on_done) Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("done_pulse", Done, 0);
        chk("busy_clear", Busy, 0);
        chk("tx_idle", TX, 1);
        tick();
        tick();
        chk("no_restart", Busy, 0);
    endtask

    initial begin
        logic [NB*8-1:0] img;
        int guard;
        bit saw_done;

        Reset = 1'b1;
        Start = 1'b0;
        memory_data = '0;
        tick();
        tick();
        chk("rst_tx", TX, 1);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_idx", byte_index, 0);
        Reset = 1'b0;
        tick();

        img = '0;
        img[7:0]   = 8'hA5;
        img[15:8]  = 8'h3C;
        img[23:16] = 8'h07;
        img[31:24] = 8'h03;
        dump(img, 1'b0, 1'b0);

        for (int w = 0; w < NB / 4; w++) img[w*32 +: 32] = $urandom;
        dump(img, 1'b1, 1'b1);

        for (int w = 0; w < NB / 4; w++) img[w*32 +: 32] = $urandom;
        memory_data = img;
        Start = 1'b1;
        push_image(img);
        tick();
        Start = 1'b0;
        guard = 0;
        while (byte_index != 5 && guard < 1000) begin
            tick();
            guard++;
        end
        chk("reach_byte5", byte_index, 5);
        repeat (8) tick();
        Reset = 1'b1;
        tick();
        chk("abort_tx", TX, 1);
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        chk("abort_idx", byte_index, 0);
        sb.delete();
        tick();
        Reset = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (Done || Busy || !TX) saw_done = 1;
        end
        chk("quiet_after_abort", saw_done, 0);

        for (int w = 0; w < NB / 4; w++) img[w*32 +: 32] = $urandom;
        dump(img, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
